// File: rtl/pmem_arb_pkg.sv
// Shared types for the I/D physical-memory arbiter.
//   Defines the arbiter FSM states, the owner/priority encoding, the captured
//   operation type and the address/line widths used by the memory port.
package pmem_arb_pkg;

    localparam int unsigned PMEM_ADDR_W = 32;
    localparam int unsigned PMEM_LINE_W = 256;

    typedef logic [PMEM_ADDR_W-1:0] addr_t;
    typedef logic [PMEM_LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // Bit positions in the req/grant vectors follow this encoding.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/pmem_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   req[0]   : I-cache pending      req[1]   : D-cache pending
//   prio     : side that wins when both are pending (OWN_I / OWN_D)
//   grant    : one-hot grant, zero when nothing is pending
module rr_arb2
    import pmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (prio == OWN_D) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache.
//   i_* / d_*  : per-cache read/write request, address, writeback data in;
//                resp pulse and read data out
//   pmem_*     : shared memory port; strobes held until pmem_resp,
//                address and write data come from registers captured at grant
//   clk, rst   : clock, synchronous active-high reset
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = PMEM_ADDR_W,
    parameter int unsigned LINE_WIDTH = PMEM_LINE_W
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    arb_state_t            state_q, state_d;
    owner_t                prio_q,  prio_d;
    op_t                   op_q,    op_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic [1:0] req;
    logic [1:0] grant;

    assign req = {d_read | d_write, i_read | i_write};

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .prio  (prio_q),
        .grant (grant)
    );

    // State and captured-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= OWN_D;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state: grant only from IDLE; requester inputs ignored while serving.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    state_d = SERVE_I;
                    op_d    = i_write ? OP_WRITE : OP_READ;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                end else if (grant[1]) begin
                    state_d = SERVE_D;
                    op_d    = d_write ? OP_WRITE : OP_READ;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    prio_d  = OWN_D;
                    state_d = DONE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    prio_d  = OWN_I;
                    state_d = DONE;
                end
            end
            // Dead cycle so a requester dropping after resp is not re-granted.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: strobes from the registered state, resp passes pmem_resp to the owner.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        i_rdata    = pmem_rdata;
        d_rdata    = pmem_rdata;
        case (state_q)
            SERVE_I: begin
                pmem_read  = (op_q == OP_READ);
                pmem_write = (op_q == OP_WRITE);
                i_resp     = pmem_resp;
            end
            SERVE_D: begin
                pmem_read  = (op_q == OP_READ);
                pmem_write = (op_q == OP_WRITE);
                d_resp     = pmem_resp;
            end
            default: ;
        endcase
    end

    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;
    import pmem_arb_pkg::*;

    logic  clk;
    logic  rst;
    logic  i_read, i_write, d_read, d_write;
    addr_t i_addr, d_addr, pmem_addr;
    line_t i_wdata, d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
    logic  i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

    int total;
    int bad;

    line_t pat_a, wd_i, wd_d;

    pmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_resp     (i_resp),
        .i_rdata    (i_rdata),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_resp     (d_resp),
        .d_rdata    (d_rdata),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_resp  (pmem_resp),
        .pmem_rdata (pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        ir;
        logic        iw;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic        pr;
        logic        erd;
        logic        ewr;
        logic [31:0] eaddr;
        logic [1:0]  ew;   // expected pmem_wdata: 0 zero, 1 I data, 2 D data
        logic        eir;
        logic        edr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ir, input logic iw, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da, input logic pr,
                       input logic erd, input logic ewr, input logic [31:0] eaddr,
                       input logic [1:0] ew, input logic eir, input logic edr);
        vec_t v;
        v.rst = r; v.ir = ir; v.iw = iw; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
        v.pr = pr; v.erd = erd; v.ewr = ewr; v.eaddr = eaddr; v.ew = ew;
        v.eir = eir; v.edr = edr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input line_t got, input line_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, got, exp);
        end
    endtask

    function automatic line_t wsel(input logic [1:0] s);
        line_t r;
        case (s)
            2'd1:    r = wd_i;
            2'd2:    r = wd_d;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic drive(input logic r, input logic ir, input logic iw, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da, input logic pr);
        rst = r; i_read = ir; i_write = iw; i_addr = ia;
        d_read = dr; d_write = dw; d_addr = da; pmem_resp = pr;
    endtask

    int lat;

    initial begin
        total = 0;
        bad   = 0;
        pat_a = {8{32'hA5C3_1E0F}};
        wd_i  = {8{32'h1234_5678}};
        wd_d  = {8{32'hDEAD_BEEF}};
        i_wdata    = wd_i;
        d_wdata    = wd_d;
        pmem_rdata = pat_a;
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // single I read at 0x1000, memory answers on the 3rd strobe cycle
        add(0,1,0,32'h1000,0,0,0,0, 0,0,32'h0,   0,0,0);
        add(0,1,0,32'h1000,0,0,0,0, 1,0,32'h1000,1,0,0);
        add(0,1,0,32'h1000,0,0,0,0, 1,0,32'h1000,1,0,0);
        add(0,1,0,32'h1000,0,0,0,1, 1,0,32'h1000,1,1,0);
        add(0,0,0,0,      0,0,0,0, 0,0,32'h1000,1,0,0);
        add(0,0,0,0,      0,0,0,0, 0,0,32'h1000,1,0,0);
        add(1,0,0,0,      0,0,0,0, 0,0,32'h1000,1,0,0);
        // both read at reset prio: D first, then I, then D wins again
        add(0,1,0,32'h3000,1,0,32'h4000,0, 0,0,32'h0,   0,0,0);
        add(0,1,0,32'h3000,1,0,32'h4000,0, 1,0,32'h4000,2,0,0);
        add(0,1,0,32'h3000,1,0,32'h4000,1, 1,0,32'h4000,2,0,1);
        add(0,1,0,32'h3000,0,0,0,      0, 0,0,32'h4000,2,0,0);
        add(0,1,0,32'h3000,0,0,0,      0, 0,0,32'h4000,2,0,0);
        add(0,1,0,32'h3000,0,0,0,      1, 1,0,32'h3000,1,1,0);
        add(0,0,0,0,       0,0,0,      0, 0,0,32'h3000,1,0,0);
        add(0,1,0,32'h3000,1,0,32'h4000,0, 0,0,32'h3000,1,0,0);
        add(0,1,0,32'h3000,1,0,32'h4000,1, 1,0,32'h4000,2,0,1);
        add(0,0,0,0,       0,0,0,      0, 0,0,32'h4000,2,0,0);
        add(0,0,0,0,       0,0,0,      0, 0,0,32'h4000,2,0,0);
        // D write with read also set: write wins
        add(0,0,0,0,1,1,32'h2020,0, 0,0,32'h4000,2,0,0);
        add(0,0,0,0,1,1,32'h2020,0, 0,1,32'h2020,2,0,0);
        add(0,0,0,0,1,1,32'h2020,1, 0,1,32'h2020,2,0,1);
        add(0,0,0,0,0,0,0,       0, 0,0,32'h2020,2,0,0);
        add(0,0,0,0,0,0,0,       0, 0,0,32'h2020,2,0,0);
        // D drops request mid-service; re-raise in DONE is not granted
        add(0,0,0,0,1,0,32'h5000,0, 0,0,32'h2020,2,0,0);
        add(0,0,0,0,0,0,0,       0, 1,0,32'h5000,2,0,0);
        add(0,0,0,0,0,0,0,       1, 1,0,32'h5000,2,0,1);
        add(0,0,0,0,1,0,32'h5000,0, 0,0,32'h5000,2,0,0);
        add(0,0,0,0,0,0,0,       0, 0,0,32'h5000,2,0,0);
        // I holds continuously, D requests once: order I, D, I
        add(0,1,0,32'h6000,0,0,0,       0, 0,0,32'h5000,2,0,0);
        add(0,1,0,32'h6000,1,0,32'h7000,1, 1,0,32'h6000,1,1,0);
        add(0,1,0,32'h6000,1,0,32'h7000,0, 0,0,32'h6000,1,0,0);
        add(0,1,0,32'h6000,1,0,32'h7000,0, 0,0,32'h6000,1,0,0);
        add(0,1,0,32'h6000,1,0,32'h7000,1, 1,0,32'h7000,2,0,1);
        add(0,1,0,32'h6000,0,0,0,       0, 0,0,32'h7000,2,0,0);
        add(0,1,0,32'h6000,0,0,0,       0, 0,0,32'h7000,2,0,0);
        add(0,1,0,32'h6000,0,0,0,       1, 1,0,32'h6000,1,1,0);
        add(0,0,0,0,       0,0,0,       0, 0,0,32'h6000,1,0,0);
        add(0,0,0,0,       0,0,0,       0, 0,0,32'h6000,1,0,0);
        // reset during SERVE_I, stale pmem_resp afterwards ignored, then normal grant
        add(0,1,0,32'h8000,0,0,0,0, 0,0,32'h6000,1,0,0);
        add(0,1,0,32'h8000,0,0,0,0, 1,0,32'h8000,1,0,0);
        add(1,1,0,32'h8000,0,0,0,0, 1,0,32'h8000,1,0,0);
        add(0,0,0,0,       0,0,0,1, 0,0,32'h0,   0,0,0);
        add(0,1,0,32'h9000,0,0,0,0, 0,0,32'h0,   0,0,0);
        add(0,1,0,32'h9000,0,0,0,1, 1,0,32'h9000,1,1,0);
        add(0,0,0,0,       0,0,0,0, 0,0,32'h9000,1,0,0);
        add(0,0,0,0,       0,0,0,0, 0,0,32'h0,   0,0,0);
        // last row expects IDLE with the held address
        vecs[vecs.size()-1].eaddr = 32'h9000;
        vecs[vecs.size()-1].ew    = 2'd1;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pmem_read",  -1, line_t'(pmem_read),  '0);
        chk("rst_pmem_write", -1, line_t'(pmem_write), '0);
        chk("rst_i_resp",     -1, line_t'(i_resp),     '0);
        chk("rst_d_resp",     -1, line_t'(d_resp),     '0);
        chk("rst_pmem_addr",  -1, line_t'(pmem_addr),  '0);
        chk("rst_pmem_wdata", -1, pmem_wdata,          '0);

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            drive(vecs[k].rst, vecs[k].ir, vecs[k].iw, vecs[k].ia,
                  vecs[k].dr, vecs[k].dw, vecs[k].da, vecs[k].pr);
            #2;
            chk("pmem_read",  k, line_t'(pmem_read),  line_t'(vecs[k].erd));
            chk("pmem_write", k, line_t'(pmem_write), line_t'(vecs[k].ewr));
            chk("pmem_addr",  k, line_t'(pmem_addr),  line_t'(vecs[k].eaddr));
            chk("pmem_wdata", k, pmem_wdata,          wsel(vecs[k].ew));
            chk("i_resp",     k, line_t'(i_resp),     line_t'(vecs[k].eir));
            chk("d_resp",     k, line_t'(d_resp),     line_t'(vecs[k].edr));
            if (vecs[k].eir) chk("i_rdata", k, i_rdata, pat_a);
            if (vecs[k].edr) chk("d_rdata", k, d_rdata, pat_a);
        end

        // latency and regrant gap: D granted (prio D), I pending throughout
        @(posedge clk); #1;
        drive(0, 1, 0, 32'hB000, 1, 0, 32'hA000, 0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            #2;
        end while (!pmem_read && lat < 8);
        chk("seq_strobe_latency", 100, line_t'(lat), line_t'(1));
        chk("seq_d_addr",         100, line_t'(pmem_addr), line_t'(32'hA000));
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        #2;
        chk("seq_hold_read", 101, line_t'(pmem_read), line_t'(1));
        @(posedge clk); #1;
        pmem_resp = 1'b1;
        #2;
        chk("seq_d_resp", 102, line_t'(d_resp), line_t'(1));
        chk("seq_i_quiet", 102, line_t'(i_resp), line_t'(0));
        @(posedge clk); #1;
        drive(0, 1, 0, 32'hB000, 0, 0, 0, 0);
        #2;
        chk("seq_done_idle", 103, line_t'(pmem_read), line_t'(0));
        @(posedge clk); #3;
        chk("seq_idle_gap", 104, line_t'(pmem_read), line_t'(0));
        @(posedge clk); #3;
        chk("seq_i_strobe", 105, line_t'(pmem_read), line_t'(1));
        chk("seq_i_addr",   105, line_t'(pmem_addr), line_t'(32'hB000));
        @(posedge clk); #1;
        pmem_resp = 1'b1;
        #2;
        chk("seq_i_resp", 106, line_t'(i_resp), line_t'(1));
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
